seg7_scan_driver: RTL

//  Time-multiplexed driver for an N-digit common-anode 7-segment display.

---
 rtl/seg7_scan_driver.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with a shadow value register.
// Optional leading-zero blanking is compiled in when SEG_LZB_EN is defined.
module seg7_scan_driver #(
    parameter int N_DIGITS      = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0]       PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    localparam logic [6:0]          SEG_BLANK  = 7'h7F;

    logic [4*N_DIGITS-1:0] shadow_reg, shadow_next;
    logic [PW-1:0]         presc_reg, presc_next;
    logic [IW-1:0]         idx_reg, idx_next;
    logic [6:0]            seg_reg, seg_next;
    logic [N_DIGITS-1:0]   an_reg, an_next;
    logic                  tick_reg, tick_next;

    logic [3:0]            nib [N_DIGITS];
    logic [N_DIGITS-1:0]   onehot;
    logic [3:0]            cur_nib;
    logic                  cur_blank;

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: dec = 7'h40;  4'h1: dec = 7'h79;  4'h2: dec = 7'h24;  4'h3: dec = 7'h30;
            4'h4: dec = 7'h19;  4'h5: dec = 7'h12;  4'h6: dec = 7'h02;  4'h7: dec = 7'h78;
            4'h8: dec = 7'h00;  4'h9: dec = 7'h10;  4'hA: dec = 7'h08;  4'hB: dec = 7'h03;
            4'hC: dec = 7'h46;  4'hD: dec = 7'h21;  4'hE: dec = 7'h06;  default: dec = 7'h0E;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign nib[gi]    = shadow_reg[4*gi +: 4];
            assign onehot[gi] = (idx_reg == IW'(gi));
        end
    endgenerate

`ifdef SEG_LZB_EN
    // lz[k] is set when nibbles k..N_DIGITS-1 of the shadow are all zero.
    logic [N_DIGITS-1:0] lz;
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lz
            if (gi == N_DIGITS - 1) begin : g_top
                assign lz[gi] = (nib[gi] == 4'h0);
            end else begin : g_mid
                assign lz[gi] = (nib[gi] == 4'h0) && lz[gi+1];
            end
        end
    endgenerate
`endif

    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_reg == IW'(k)) begin
                cur_nib = nib[k];
`ifdef SEG_LZB_EN
                cur_blank = (k != 0) && lz[k];
`endif
            end
        end
    end

    always_comb begin
        shadow_next = load ? value : shadow_reg;
        presc_next  = presc_reg;
        idx_next    = idx_reg;
        tick_next   = 1'b0;
        seg_next    = SEG_BLANK;
        an_next     = AN_OFF;
        if (enable) begin
            if (presc_reg == PRESC_LAST) begin
                presc_next = '0;
                idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
                tick_next  = (idx_reg == IDX_LAST);
            end else begin
                presc_next = presc_reg + 1'b1;
            end
            // Outputs reflect idx/shadow as they were before this edge.
            seg_next = cur_blank ? SEG_BLANK : dec(cur_nib);
            an_next  = AN_ACTIVE_LOW ? ~onehot : onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_reg <= '0;
            presc_reg  <= '0;
            idx_reg    <= '0;
            seg_reg    <= SEG_BLANK;
            an_reg     <= AN_OFF;
            tick_reg   <= 1'b0;
        end else begin
            shadow_reg <= shadow_next;
            presc_reg  <= presc_next;
            idx_reg    <= idx_next;
            seg_reg    <= seg_next;
            an_reg     <= an_next;
            tick_reg   <= tick_next;
        end
    end

    assign seg        = seg_reg;
    assign an         = an_reg;
    assign frame_tick = tick_reg;

endmodule
